// File: rtl/frame_scheduler.sv
// Per-frame update sequencer: on the first blanking line it walks the game engines
// through PADDLE, BALL, COLLIDE and SCORE, then commits, or aborts if video restarts.
module frame_scheduler #(
   parameter int V_VISIBLE = 480,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_tick,
   input  logic [9:0]       pixel_x,
   input  logic [9:0]       pixel_y,
   input  logic             pause,
   input  logic [3:0]       upd_done,
   output logic [3:0]       upd_req,
   output logic             commit,
   output logic             frame_abort,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] overrun_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PADDLE,
      S_BALL,
      S_COLLIDE,
      S_SCORE,
      S_COMMIT,
      S_ABORT
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       upd_req_q, upd_req_d;
   logic             commit_q, commit_d;
   logic             frame_abort_q, frame_abort_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0] overrun_cnt_q, overrun_cnt_d;

   logic             ftick;
   logic             vstart;
   logic [CNT_W-1:0] cnt_one;

   assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
   assign ftick   = p_tick && (pixel_y == 10'(V_VISIBLE)) && (pixel_x == 10'd0);
   assign vstart  = p_tick && (pixel_y == 10'd0) && (pixel_x == 10'd0);

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      overrun_cnt_d = overrun_cnt_q;

      // A tick that lands while a frame is still in flight is counted, never restarted.
      if (ftick) begin
         frame_cnt_d = frame_cnt_q + cnt_one;
         if ((state_q != S_IDLE) && (overrun_cnt_q != {CNT_W{1'b1}})) begin
            overrun_cnt_d = overrun_cnt_q + cnt_one;
         end
      end

      case (state_q)
         S_IDLE:    if (ftick && !pause) state_d = S_PADDLE;
         S_PADDLE:  if (vstart) state_d = S_ABORT; else if (upd_done[0]) state_d = S_BALL;
         S_BALL:    if (vstart) state_d = S_ABORT; else if (upd_done[1]) state_d = S_COLLIDE;
         S_COLLIDE: if (vstart) state_d = S_ABORT; else if (upd_done[2]) state_d = S_SCORE;
         S_SCORE:   if (vstart) state_d = S_ABORT; else if (upd_done[3]) state_d = S_COMMIT;
         S_COMMIT:  state_d = S_IDLE;
         S_ABORT:   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Outputs decode the next state so they are registered yet valid in the state's first cycle.
      case (state_d)
         S_PADDLE:  upd_req_d = 4'b0001;
         S_BALL:    upd_req_d = 4'b0010;
         S_COLLIDE: upd_req_d = 4'b0100;
         S_SCORE:   upd_req_d = 4'b1000;
         default:   upd_req_d = 4'b0000;
      endcase
      commit_d      = (state_d == S_COMMIT);
      frame_abort_d = (state_d == S_ABORT);
      busy_d        = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         upd_req_q     <= 4'b0000;
         commit_q      <= 1'b0;
         frame_abort_q <= 1'b0;
         busy_q        <= 1'b0;
         frame_cnt_q   <= '0;
         overrun_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         upd_req_q     <= upd_req_d;
         commit_q      <= commit_d;
         frame_abort_q <= frame_abort_d;
         busy_q        <= busy_d;
         frame_cnt_q   <= frame_cnt_d;
         overrun_cnt_q <= overrun_cnt_d;
      end
   end

   assign upd_req     = upd_req_q;
   assign commit      = commit_q;
   assign frame_abort = frame_abort_q;
   assign busy        = busy_q;
   assign frame_cnt   = frame_cnt_q;
   assign overrun_cnt = overrun_cnt_q;

endmodule
